// File: rtl/friscv_stats_ctrl.sv
// Performance-statistics controller: four event counters with
// enable/clear/snapshot sequencing and a valid/ready register port.
module friscv_stats_ctrl #(
  parameter int XLEN        = 32,
  parameter bit EN_AT_RESET = 1'b1
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic            inst_en,
  input  logic            inst_ready,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_wr,
  input  logic [2:0]      req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t          state;
  logic            l_wr;
  logic [2:0]      l_addr;
  logic [3:0]      l_wdata;
  logic            enable;
  logic [3:0]      ovf;
  logic [XLEN-1:0] cnt  [4];
  logic [XLEN-1:0] snap [4];

  logic [3:0]      ev;
  logic [3:0]      inc;
  logic [3:0]      wrap;
  logic [3:0]      w1c;
  logic            is_exec;
  logic            acc_err;
  logic            ctrl_wr;
  logic            stat_wr;
  logic            do_clr;
  logic            do_snap;
  logic            sel_ctrl;
  logic            sel_stat;
  logic            sel_snap;
  logic [1:0]      snap_idx;
  logic [XLEN-1:0] rd_val;
  logic            unused_wdata;

  assign unused_wdata = ^req_wdata[XLEN-1:4];

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  assign ev = {~inst_en,
               inst_en & inst_ready,
               inst_en & ~inst_ready,
               1'b1};
  assign inc = {4{enable}} & ev;

  assign is_exec  = (state == EXEC);
  assign acc_err  = (l_addr >= 3'd6)
                  | (l_wr & (l_addr >= 3'd2));
  assign ctrl_wr  = is_exec & l_wr
                  & (l_addr == 3'd0);
  assign stat_wr  = is_exec & l_wr
                  & (l_addr == 3'd1);
  assign do_clr   = ctrl_wr & l_wdata[1];
  assign do_snap  = ctrl_wr & l_wdata[2];
  assign w1c      = stat_wr ? l_wdata : 4'b0;

  // A clear in the same cycle suppresses the increment, so no wrap either
  always_comb begin
    wrap = '0;
    for (int i = 0; i < 4; i++) begin
      wrap[i] = inc[i] & ~do_clr & (&cnt[i]);
    end
  end

  assign sel_ctrl = (l_addr == 3'd0);
  assign sel_stat = (l_addr == 3'd1);
  assign sel_snap = (l_addr >= 3'd2)
                  & (l_addr <= 3'd5);
  assign snap_idx = 2'(l_addr - 3'd2);

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      sel_ctrl: rd_val = XLEN'(enable);
      sel_stat: rd_val = XLEN'({enable, 4'b0, ovf});
      sel_snap: rd_val = snap[snap_idx];
      default:  rd_val = '0;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      ovf <= '0;
      for (int i = 0; i < 4; i++) begin
        cnt[i]  <= '0;
        snap[i] <= '0;
      end
    end else begin
      ovf <= (ovf & ~w1c) | wrap;
      for (int i = 0; i < 4; i++) begin
        if (do_clr)
          cnt[i] <= '0;
        else if (inc[i])
          cnt[i] <= cnt[i] + 1'b1;
        if (do_snap)
          snap[i] <= cnt[i];
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state     <= IDLE;
      l_wr      <= 1'b0;
      l_addr    <= '0;
      l_wdata   <= '0;
      enable    <= EN_AT_RESET;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            l_wr    <= req_wr;
            l_addr  <= req_addr;
            l_wdata <= req_wdata[3:0];
            state   <= EXEC;
          end
        end
        EXEC: begin
          rsp_err   <= acc_err;
          rsp_rdata <= (acc_err | l_wr) ? '0 : rd_val;
          if (ctrl_wr)
            enable <= l_wdata[0];
          state <= RESP;
        end
        RESP: begin
          if (rsp_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
